// File: rtl/onehot_decoder_seq.sv
// Sequenced one-hot decoder: decodes a select index into a registered one-hot
// vector, holds it, or auto-scans it with a programmable per-position dwell.
module onehot_decoder_seq #(
    parameter int N       = 3,
    parameter int DWELL_W = 4,
    localparam int OUTS   = 2**N
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       sel,
    input  logic [DWELL_W-1:0] dwell,
    output logic [OUTS-1:0]    d,
    output logic [N-1:0]       idx,
    output logic               wrap,
    output logic               busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HOLD = 2'b01,
        ST_SCAN = 2'b10
    } state_t;

    localparam logic [N-1:0]       IDX_ONE = N'(1);
    localparam logic [N-1:0]       IDX_MAX = N'(OUTS - 1);
    localparam logic [DWELL_W-1:0] CNT_ONE = DWELL_W'(1);

    state_t               state_q, state_d;
    logic [OUTS-1:0]      d_q, d_d;
    logic [N-1:0]         idx_q, idx_d;
    logic                 wrap_q, wrap_d;
    logic                 busy_q, busy_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic                 accept_s;
    logic                 advance_s;

    function automatic logic [OUTS-1:0] onehot_f(input logic [N-1:0] i);
        logic [OUTS-1:0] v;
        v    = {OUTS{1'b0}};
        v[i] = 1'b1;
        return v;
    endfunction

    // Handshake: ready is suppressed during reset so nothing is accepted on the release edge.
    assign in_ready  = en & ~rst & (state_q != ST_SCAN);
    assign accept_s  = in_valid & in_ready;
    assign advance_s = (state_q == ST_SCAN) && (cnt_q == dwell_q);

    // Next-state logic; shutdown by en has priority over any request.
    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        idx_d   = idx_q;
        wrap_d  = 1'b0;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        if (!en) begin
            state_d = ST_IDLE;
            d_d     = {OUTS{1'b0}};
            cnt_d   = {DWELL_W{1'b0}};
        end else if (accept_s) begin
            d_d   = onehot_f(sel);
            idx_d = sel;
            if (mode) begin
                state_d = ST_SCAN;
                dwell_d = dwell;
                cnt_d   = {DWELL_W{1'b0}};
            end else begin
                state_d = ST_HOLD;
            end
        end else if (state_q == ST_SCAN) begin
            if (advance_s) begin
                idx_d  = idx_q + IDX_ONE;
                d_d    = {d_q[OUTS-2:0], d_q[OUTS-1]};
                cnt_d  = {DWELL_W{1'b0}};
                wrap_d = (idx_q == IDX_MAX);
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            state_d = state_q;
        end
        busy_d = (state_d == ST_SCAN);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            d_q     <= {OUTS{1'b0}};
            idx_q   <= {N{1'b0}};
            wrap_q  <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= {DWELL_W{1'b0}};
            dwell_q <= {DWELL_W{1'b0}};
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
        end
    end

    assign d    = d_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;
    assign busy = busy_q;

endmodule

// File: doc/onehot_decoder_seq.md
ONEHOT_DECODER_SEQ -- requirements
Module: onehot_decoder_seq

Interface
REQ-001 Parameter N, default 3: select width; output count is OUTS = 2**N, and legal N is 1..6.
REQ-002 Parameter DWELL_W, default 4: dwell counter width; legal DWELL_W is 1..16.
REQ-003 clk  input  1  The single clock; all state updates on its rising edge.
REQ-004 rst  input  1  Reset, asynchronous and active-high.
REQ-005 en  input  1  Block enable; when low, forces shutdown (see REQ-012).
REQ-006 mode  input  1  Request mode, sampled on accept: 0 = decode/hold, 1 = scan.
REQ-007 in_valid  input  1  Request valid.
REQ-008 in_ready  output  1  Block can accept a request.
REQ-009 sel  input  N  Decode index, or scan start index.
REQ-010 dwell  input  DWELL_W  Scan dwell: each position is held for dwell+1 cycles.
REQ-011 Outputs:
- d  output  OUTS  Registered one-hot output; d[i] high means index i is selected.
- idx  output  N  Binary index of the currently asserted d bit.
- wrap  output  1  One-cycle pulse when a scan wraps from OUTS-1 to 0.
- busy  output  1  High while in SCAN.

Function
REQ-012 States:
- IDLE (d = 0);
- HOLD (d = one-hot, static);
- SCAN (d = one-hot, auto-advancing).
- en = 0 in any state: next state is IDLE, d = 0, wrap = 0, dwell counter = 0, idx held; this has priority over any handshake.
REQ-013 in_ready = en & (state != SCAN), derived combinationally from the registered state.
REQ-014 A request is accepted on a rising edge where in_valid & in_ready = 1; in_valid without in_ready is ignored and is not queued.
REQ-015 Decode accept (mode = 0), from IDLE or HOLD, latency 1 cycle:
- d <= 1 << sel;
- idx <= sel;
- state <= HOLD.
REQ-016 HOLD keeps d and idx constant until another accept occurs or en = 0.
REQ-017 Scan accept (mode = 1), from IDLE or HOLD, latency 1 cycle:
- d <= 1 << sel, idx <= sel;
- dwell is latched into an internal reload register, and the counter is cleared to 0;
- state <= SCAN.
REQ-018 In SCAN, the counter increments each cycle.
- When counter == latched dwell: idx <= idx + 1 modulo OUTS, d is rotated left by 1 (bit OUTS-1 wraps to bit 0), and the counter is cleared to 0.
REQ-019 wrap is asserted for exactly the one cycle in which d = 1 and idx = 0 following an advance from idx = OUTS-1; it is registered together with d.
REQ-020 dwell = 0 advances every cycle; dwell = 2**DWELL_W-1 holds each position for 2**DWELL_W cycles.
- Changes on the dwell port during SCAN have no effect.
REQ-021 SCAN is exited only by en = 0; in_valid during SCAN is ignored.
REQ-022 Invariants:
- d is always either all-zero (IDLE) or exactly one-hot;
- d == (1 << idx) whenever state != IDLE.
REQ-023 busy = (state == SCAN), registered.

Reset
REQ-024 While rst = 1, asynchronously:
- state = IDLE;
- d = 0, idx = 0, wrap = 0, busy = 0;
- counter = 0, latched dwell = 0.
REQ-025 in_ready is 0 while rst is high.
- After rst deasserts, in_ready is 1 in the first cycle, provided en = 1.
REQ-026 Reset asserted mid-SCAN or mid-HOLD aborts immediately; no wrap pulse is produced.

Verification
REQ-027 N=3, en=1, decode sel=5 -> d=8'b0010_0000, idx=5 one cycle after accept; d holds for 10 cycles.
REQ-028 N=3, scan sel=6, dwell=0 -> idx sequence 6,7,0,1 on successive cycles; wrap=1 only in the cycle with idx=0.
REQ-029 N=3, scan sel=0, dwell=2 -> each idx is held 3 cycles; the first wrap is 24 cycles after accept; in_ready=0 and busy=1 throughout.
REQ-030 A scan is running and en drops -> next cycle d=0, busy=0, wrap=0; when en returns, in_ready=1, and decode sel=2 gives d=8'b0000_0100.
REQ-031 In HOLD with d=8'h08, in_valid=1 with rst pulsed asynchronously mid-cycle -> d=0 and idx=0 immediately; no accept occurs on that edge.
REQ-032 N=1 build: decode sel=1 gives d=2'b10; scan with dwell=0 toggles d every cycle and pulses wrap every 2 cycles.
